// File: rtl/irq_priority_encoder_pkg.sv
// Shared constants for the interrupt / key-scan priority encoder.
// Enable code, FSM state encodings and helper functions.
package irq_priority_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  // {G1,G2} value that enables the block; shared with the 3-8 decoder
  localparam logic [1:0] ENA_ON = 2'b10;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [CODE_W-1:0] idx
  );
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_priority_encoder_prio_enc8.sv
// prio_enc8: 8-bit vector to {any, index of highest set bit}.
// Ports: vec_i (vector), any_o (any bit set), idx_o (highest index).
module prio_enc8
  import irq_priority_encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  vec_i,
  output logic              any_o,
  output logic [CODE_W-1:0] idx_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec_i[i]) idx_o = CODE_W'(i);
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// Sequential 8-to-3 priority encoder with falling-edge capture and
// valid/ack handshake. Ports: iClk, iRst_n, iReq_n, iEna, iAck ->
// oData (granted index), oValid (code presented), oGS_n (any pending).
module irq_priority_encoder
  import irq_priority_encoder_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [N_REQ-1:0]  iReq_n,
  input  logic [1:0]        iEna,
  input  logic              iAck,
  output logic [CODE_W-1:0] oData,
  output logic              oValid,
  output logic              oGS_n
);

  logic [N_REQ-1:0]  prev_n_q;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [0:0]        st_q, st_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  fall;
  logic [N_REQ-1:0]  clr;
  logic              en;
  logic              any;
  logic [CODE_W-1:0] idx;

  prio_enc8 u_prio (
    .vec_i (pend_q),
    .any_o (any),
    .idx_o (idx)
  );

  always_comb begin
    fall   = prev_n_q & ~iReq_n;
    en     = (iEna == ENA_ON);
    clr    = '0;
    pend_d = pend_q;
    st_d   = st_q;
    data_d = data_q;
    if (st_q == GRANT && iAck) clr = onehot(data_q);
    if (!en) begin
      pend_d = '0;
      st_d   = IDLE;
      data_d = '0;
    end else begin
      // OR-ing fall last lets a new edge beat its own clear
      pend_d = (pend_q & ~clr) | fall;
      unique case (st_q)
        IDLE: begin
          if (any) begin
            st_d   = GRANT;
            data_d = idx;
          end
        end
        GRANT: begin
          if (iAck) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      prev_n_q <= '1;
      pend_q   <= '0;
      st_q     <= IDLE;
      data_q   <= '0;
    end else begin
      prev_n_q <= iReq_n;
      pend_q   <= pend_d;
      st_q     <= st_d;
      data_q   <= data_d;
    end
  end

  assign oData  = data_q;
  assign oValid = (st_q == GRANT);
  assign oGS_n  = ~|pend_q;

endmodule
